// File: rtl/seq_match_sched_if.sv
// Requester/config/result bundle between parallel producers and seq_match_sched.
// The master side drives requests and configuration; the slave side is the scheduler.
interface seq_match_sched_if #(
  parameter int NREQ   = 4,
  parameter int WORD_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 4
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic                     cfg_we;
  logic [PAT_W-1:0]         cfg_pat;
  logic [NREQ-1:0]          req;
  logic [NREQ*WORD_W-1:0]   req_data;
  logic [NREQ-1:0]          gnt;
  logic                     busy;
  logic                     bit_out;
  logic                     match;
  logic                     done;
  logic [ID_W-1:0]          done_id;
  logic [CNT_W-1:0]         hit_cnt;

  modport master (
    output cfg_we, cfg_pat, req, req_data,
    input  gnt, busy, bit_out, match, done, done_id, hit_cnt
  );

  modport slave (
    input  cfg_we, cfg_pat, req, req_data,
    output gnt, busy, bit_out, match, done, done_id, hit_cnt
  );
endinterface

// File: rtl/seq_match_sched.sv
// Round-robin scheduler feeding one bit-serial Moore pattern matcher; each granted
// word is shifted MSB-first, overlapping hits are counted and reported with the ID.
module seq_match_sched #(
  parameter int               NREQ        = 4,
  parameter int               WORD_W      = 8,
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = 4'b1010,
  parameter int               CNT_W       = 4
) (
  input logic               clk,
  input logic               reset,
  seq_match_sched_if.slave  bus
);

  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     cur_id_q, cur_id_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [PAT_W-1:0]    hist_q, hist_d, hist_nxt;
  logic [WORD_W-1:0]   sh_q, sh_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                match_q, match_d;

  logic                found;
  logic [ID_W-1:0]     win;
  logic [NREQ-1:0]     gnt_d;
  logic                bit_cur;
  logic                hit;

  // Circular first-set search starting at rr_ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      logic [ID_W:0] j;
      j = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (j >= (ID_W+1)'(NREQ)) j = j - (ID_W+1)'(NREQ);
      if (!found && bus.req[j[ID_W-1:0]]) begin
        found = 1'b1;
        win   = j[ID_W-1:0];
      end
    end
  end

  // The word is kept as a left-shifting register, so the MSB is always the current bit.
  assign bit_cur  = (state_q == SHIFT) ? sh_q[WORD_W-1] : 1'b0;
  assign hist_nxt = {hist_q[PAT_W-2:0], bit_cur};
  assign hit      = (state_q == SHIFT) && (int'(idx_q) + 1 >= PAT_W) && (hist_nxt == pat_q);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cur_id_d = cur_id_q;
    pat_d    = pat_q;
    hist_d   = hist_q;
    sh_d     = sh_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    match_d  = 1'b0;
    gnt_d    = '0;
    case (state_q)
      IDLE: begin
        if (bus.cfg_we) begin
          pat_d = bus.cfg_pat;
        end else if (found) begin
          gnt_d[win] = 1'b1;
          sh_d       = bus.req_data[win*WORD_W +: WORD_W];
          hist_d     = '0;
          cnt_d      = '0;
          idx_d      = '0;
          cur_id_d   = win;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        hist_d  = hist_nxt;
        sh_d    = {sh_q[WORD_W-2:0], 1'b0};
        idx_d   = idx_q + 1'b1;
        match_d = hit;
        if (hit && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        if (idx_q == IDX_W'(WORD_W-1)) state_d = REPORT;
      end
      REPORT: begin
        rr_ptr_d = (cur_id_q == ID_W'(NREQ-1)) ? '0 : cur_id_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      cur_id_q <= '0;
      pat_q    <= PAT_DEFAULT;
      hist_q   <= '0;
      sh_q     <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cur_id_q <= cur_id_d;
      pat_q    <= pat_d;
      hist_q   <= hist_d;
      sh_q     <= sh_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
    end
  end

  // cur_id/cnt are only reloaded at grant, so they double as the held result outputs.
  assign bus.gnt     = gnt_d;
  assign bus.busy    = (state_q != IDLE);
  assign bus.bit_out = bit_cur;
  assign bus.match   = match_q;
  assign bus.done    = (state_q == REPORT);
  assign bus.done_id = cur_id_q;
  assign bus.hit_cnt = cnt_q;

endmodule

// File: tb/tb_seq_match_sched.sv
// Directed bench for seq_match_sched: vector table of single-word transactions plus
// hand-written sequences for timing, round-robin order, config priority, saturation, reset.
module tb_seq_match_sched;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_match_sched_if #(.NREQ(4), .WORD_W(8), .PAT_W(4), .CNT_W(4)) m ();
  seq_match_sched_if #(.NREQ(4), .WORD_W(8), .PAT_W(4), .CNT_W(2)) m2 ();

  seq_match_sched #(.NREQ(4), .WORD_W(8), .PAT_W(4), .PAT_DEFAULT(4'b1010), .CNT_W(4))
    u_dut (.clk(clk), .reset(reset), .bus(m));

  seq_match_sched #(.NREQ(4), .WORD_W(8), .PAT_W(4), .PAT_DEFAULT(4'b1111), .CNT_W(2))
    u_sat (.clk(clk), .reset(reset), .bus(m2));

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int         id;
    logic [7:0] word;
    int         cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output logic [3:0] g);
    logic seen;
    seen = 1'b0;
    g    = '0;
    for (int n = 0; n < 40 && !seen; n++) begin
      #1;
      if (m.gnt != 4'b0000) begin
        g    = m.gnt;
        seen = 1'b1;
      end else begin
        tick();
      end
    end
  endtask

  task automatic wait_done(output logic seen, output logic any_match);
    seen      = 1'b0;
    any_match = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      any_match = any_match | m.match;
      if (m.done) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic txn(input string name, input int id, input logic [7:0] w, input int exp_cnt);
    logic [3:0] g;
    logic       s, am;
    m.req_data[id*8 +: 8] = w;
    m.req[id] = 1'b1;
    wait_gnt(g);
    check({name, " gnt"}, 32'(g), 32'(1 << id));
    tick();
    m.req[id] = 1'b0;
    wait_done(s, am);
    check({name, " done"}, 32'(s), 32'd1);
    check({name, " done_id"}, 32'(m.done_id), 32'(id));
    check({name, " hit_cnt"}, 32'(m.hit_cnt), 32'(exp_cnt));
    check({name, " match_seen"}, 32'(am), 32'(exp_cnt != 0));
    tick();
  endtask

  task automatic rr_seq(input string name, input logic [3:0] reqs, input int ord[5],
                        input int n, input int cnt_of_id[4]);
    logic [3:0] g;
    logic       s, am;
    m.req = reqs;
    for (int i = 0; i < n; i++) begin
      wait_gnt(g);
      check($sformatf("%s gnt%0d", name, i), 32'(g), 32'(1 << ord[i]));
      tick();
      wait_done(s, am);
      check($sformatf("%s done%0d", name, i), 32'(s), 32'd1);
      check($sformatf("%s id%0d", name, i), 32'(m.done_id), 32'(ord[i]));
      check($sformatf("%s cnt%0d", name, i), 32'(m.hit_cnt), 32'(cnt_of_id[ord[i]]));
      tick();
    end
    m.req = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] w;
    logic [3:0] g;
    logic       s, am, any_done;
    int         ord1[5];
    int         ord2[5];
    int         cnts[4];

    vecs[0] = '{2, 8'b00001010, 1};
    vecs[1] = '{0, 8'h00,       0};
    vecs[2] = '{1, 8'b01010101, 2};
    vecs[3] = '{3, 8'b10100000, 1};
    vecs[4] = '{2, 8'b11010100, 2};
    vecs[5] = '{0, 8'b00000101, 0};
    vecs[6] = '{1, 8'hFF,       0};

    reset       = 1'b0;
    m.cfg_we    = 1'b0;
    m.cfg_pat   = '0;
    m.req       = '0;
    m.req_data  = '0;
    m2.cfg_we   = 1'b0;
    m2.cfg_pat  = '0;
    m2.req      = '0;
    m2.req_data = '0;
    tick();
    tick();
    check("reset outputs", 32'({m.gnt, m.busy, m.bit_out, m.match, m.done, m.done_id, m.hit_cnt}), 32'd0);
    check("reset outputs sat", 32'({m2.gnt, m2.busy, m2.match, m2.done, m2.hit_cnt}), 32'd0);
    reset = 1'b1;
    tick();

    // Test 1: cycle-exact walk through one word with the default pattern
    w = 8'hAA;
    m.req_data[7:0] = w;
    m.req = 4'b0001;
    #1;
    check("t1 gnt", 32'(m.gnt), 32'd1);
    check("t1 busy idle", 32'(m.busy), 32'd0);
    tick();
    m.req = '0;
    for (int k = 1; k <= 9; k++) begin
      check($sformatf("t1 bit_out k%0d", k), 32'(m.bit_out), (k <= 8) ? 32'(w[8-k]) : 32'd0);
      check($sformatf("t1 match k%0d", k), 32'(m.match), 32'(k == 5 || k == 7 || k == 9));
      check($sformatf("t1 done k%0d", k), 32'(m.done), 32'(k == 9));
      if (k == 9) begin
        check("t1 done_id", 32'(m.done_id), 32'd0);
        check("t1 hit_cnt", 32'(m.hit_cnt), 32'd3);
      end
      tick();
    end
    check("t1 match after", 32'(m.match), 32'd0);
    check("t1 busy after", 32'(m.busy), 32'd0);
    check("t1 hit_cnt hold", 32'(m.hit_cnt), 32'd3);
    check("t1 done_id hold", 32'(m.done_id), 32'd0);

    // Table of single-word transactions
    for (int i = 0; i < 7; i++) begin
      txn($sformatf("vec%0d", i), vecs[i].id, vecs[i].word, vecs[i].cnt);
    end

    // Test 3: round-robin order with all requests held, then from rr_ptr=2
    do_reset();
    m.req_data = {8'hAA, 8'h00, 8'h0A, 8'hA0};
    cnts = '{1, 1, 0, 3};
    ord1 = '{0, 1, 2, 3, 0};
    rr_seq("t3 all", 4'b1111, ord1, 5, cnts);
    txn("t3 single1", 1, 8'h0A, 1);
    ord2 = '{3, 0, 1, 0, 0};
    rr_seq("t3 1011", 4'b1011, ord2, 3, cnts);

    // Test 4: config beats grant in IDLE; config during SHIFT is ignored
    m.cfg_we  = 1'b1;
    m.cfg_pat = 4'b1111;
    m.req_data[15:8] = 8'hFF;
    m.req[1] = 1'b1;
    #1;
    check("t4 no gnt on cfg", 32'(m.gnt), 32'd0);
    tick();
    m.cfg_we = 1'b0;
    #1;
    check("t4 gnt next", 32'(m.gnt), 32'b0010);
    tick();
    m.req = '0;
    m.cfg_we  = 1'b1;
    m.cfg_pat = 4'b0000;
    tick();
    m.cfg_we = 1'b0;
    wait_done(s, am);
    check("t4 done", 32'(s), 32'd1);
    check("t4 hit_cnt", 32'(m.hit_cnt), 32'd5);
    tick();
    txn("t4 pattern kept", 1, 8'hFF, 5);
    txn("t4 pattern 0F", 2, 8'h0F, 1);

    // Test 6: reset mid-SHIFT aborts the word and restores defaults
    m.req_data[31:24] = 8'hAA;
    m.req[3] = 1'b1;
    wait_gnt(g);
    check("t6 gnt", 32'(g), 32'b1000);
    tick();
    m.req = '0;
    tick();
    tick();
    tick();
    check("t6 busy at idx3", 32'(m.busy), 32'd1);
    reset = 1'b0;
    #1;
    check("t6 outputs in reset", 32'({m.gnt, m.busy, m.bit_out, m.match, m.done, m.done_id, m.hit_cnt}), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    any_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      any_done = any_done | m.done;
      tick();
    end
    check("t6 no done after abort", 32'(any_done), 32'd0);
    m.req_data = {8'hAA, 8'h00, 8'h0A, 8'hA0};
    m.req = 4'b1111;
    #1;
    check("t6 rr_ptr reset gnt", 32'(m.gnt), 32'b0001);
    tick();
    m.req = '0;
    wait_done(s, am);
    check("t6 rr done_id", 32'(m.done_id), 32'd0);
    tick();
    txn("t6 req3 default pat", 3, 8'hAA, 3);

    // Test 5: 2-bit counter saturates on 8'hFF with pattern 1111
    s = 1'b0;
    m2.req_data[7:0] = 8'hFF;
    m2.req = 4'b0001;
    for (int n = 0; n < 40 && !s; n++) begin
      #1;
      if (m2.gnt == 4'b0001) s = 1'b1;
      else tick();
    end
    check("t5 gnt", 32'(s), 32'd1);
    tick();
    m2.req = '0;
    s = 1'b0;
    for (int n = 0; n < 40 && !s; n++) begin
      if (m2.done) s = 1'b1;
      else tick();
    end
    check("t5 done", 32'(s), 32'd1);
    check("t5 hit_cnt sat", 32'(m2.hit_cnt), 32'd3);
    check("t5 done_id", 32'(m2.done_id), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_match_sched.md
Name: seq_match_sched

Overview:
- Round-robin scheduler that shares one bit-serial, programmable Moore pattern-match engine among NREQ requesters.
- Each requester hands over a WORD_W-bit word. The block serialises the word MSB-first into the engine and counts overlapping pattern hits.
- It then reports the count with the requester ID.
- Sits between parallel producers and the serial sequence-detection logic. It also owns the engine's pattern configuration.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WORD_W, 8, bits per word
- PAT_W, 4, pattern length in bits (PAT_W <= WORD_W)
- PAT_DEFAULT, 4'b1010, pattern loaded at reset
- CNT_W, 4, width of hit counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- cfg_we  in  1  pattern write strobe
- cfg_pat  in  PAT_W  new pattern
- req  in  NREQ  per-requester request, level, held until granted
- req_data  in  NREQ*WORD_W  word of requester i at bits [i*WORD_W +: WORD_W]
- gnt  out  NREQ  one-hot grant, single-cycle pulse
- busy  out  1  high while a word is being shifted/reported
- bit_out  out  1  serial bit currently fed to engine
- match  out  1  registered Moore match flag
- done  out  1  one-cycle completion pulse
- done_id  out  clog2(NREQ)  requester ID of completed word
- hit_cnt  out  CNT_W  hits in completed word, valid with done

Behaviour:
- Reset (reset=0, async) values:
  - state=IDLE, rr_ptr=0, pattern=PAT_DEFAULT.
  - gnt=0, busy=0, bit_out=0, match=0, done=0, done_id=0, hit_cnt=0.
  - Shift history=0, bit index=0.
- Reset mid-operation: the word is aborted, no done is produced, and rr_ptr returns to 0.
- FSM IDLE:
  - If cfg_we=1: pattern<=cfg_pat at the edge. No grant is issued this cycle (config has priority over grant).
  - Else if any req: winner = first i with req[i]=1, searching circularly from rr_ptr.
    - gnt[winner]=1 combinationally this cycle.
    - Word latched; history and hit count cleared; cur_id<=winner; go SHIFT.
  - Requester must drop or change req after seeing gnt.
- FSM SHIFT (exactly WORD_W cycles, busy=1):
  - bit_out = word[WORD_W-1-idx].
  - At each edge: history <= {history[PAT_W-2:0], bit_out}; idx++.
  - A hit occurs when idx+1 >= PAT_W and the next history equals pattern.
  - On a hit: count increments, saturating at 2^CNT_W-1. match<=1 for the following cycle, else match<=0.
  - Overlapping hits are counted.
  - After the bit with idx=WORD_W-1: go REPORT.
- FSM REPORT (1 cycle, busy=1):
  - done=1, done_id=cur_id, hit_cnt=count.
  - rr_ptr <= (cur_id+1) mod NREQ; go IDLE. match returns to 0 the cycle after.
- Latency: grant in IDLE cycle T → SHIFT cycles T+1..T+WORD_W → done at cycle T+WORD_W+1. Next grant possible at T+WORD_W+2.
- cfg_we outside IDLE is ignored; the pattern is stable for a whole word.
- hit_cnt and done_id hold their values after done until the next grant.
- Simultaneous req from all requesters: service order rr_ptr, rr_ptr+1, … with no starvation.
- A req that is held through done is eligible again only after the other pending requesters are served.
- A req arriving during busy waits; it is never lost while held.

Test Plan:
1. Default pattern 1010, req[0]=1, word 8'b10101010 → gnt[0] pulse at T; bit_out 1,0,1,0,1,0,1,0; match high in cycles T+5, T+7, T+9; done at T+9 with done_id=0, hit_cnt=3.
2. req[2] word 8'b00001010 → hit_cnt=1, done_id=2. Word 8'h00 → hit_cnt=0 and match never asserted.
3. req=4'b1111 held, words distinct → done_id sequence 0,1,2,3, then 0. Second pass with rr_ptr=2 after a single req[1] transaction and req=4'b1011 → order 3,0,1.
4. In IDLE, cfg_we=1 with cfg_pat=4'b1111 and req[1]=1 in the same cycle → no gnt that cycle; gnt[1] next cycle; word 8'hFF → hit_cnt=5. cfg_we pulsed during SHIFT → pattern unchanged.
5. CNT_W=2, pattern 1111, word 8'hFF → hit_cnt saturates at 3.
6. Assert reset during SHIFT at idx=3 → all outputs 0 immediately, no done. After release, req[3] alone is granted and completes normally with pattern=PAT_DEFAULT.
